// File: rtl/uart_rx_os16.sv
// 8N1-style UART receiver: 16x oversampling, start bit validated at mid-bit,
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_os16 #(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam logic [15:0] DIV_MAX  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [15:0]          div_cnt;
  logic                 tick;
  logic [3:0]           os_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      div_cnt <= '0;
    else
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 16'd1;
  end

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // a load in STOP below overrides this drop when both happen together
      if (data_valid && data_ready)
        data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              if (!rx_s) begin
                state   <= DATA;
                os_cnt  <= '0;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              os_cnt  <= '0;
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == LAST_BIT)
                state <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (rx_s) begin
                // leaving at mid stop bit lets a back-to-back start edge be seen
                state <= IDLE;
                if (!data_valid || data_ready) begin
                  data_out   <= shreg;
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                shreg     <= '0;
                state     <= BREAK_WAIT;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        BREAK_WAIT: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: event scoreboard of expected deliveries,
// drops and framing errors, plus per-cycle holding-register rules.
module tb_uart_rx_os16;
  localparam int CLK_DIV   = 4;
  localparam int DATA_BITS = 8;
  localparam int BIT       = 16 * CLK_DIV;

  localparam int K_DELIV = 0;
  localparam int K_DROP  = 1;
  localparam int K_FERR  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } evt_t;
  evt_t q[$];

  logic       pv, pr;
  logic [7:0] pd;

  uart_rx_os16 #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    evt_t e;
    e.kind = kind;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic take(input int kind, input string nm);
    evt_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s got=event want=none", nm);
    end else begin
      e = q.pop_front();
      chk({"evt_kind_", nm}, kind, e.kind);
      if (kind == K_DELIV)
        chk("evt_data", 32'(data_out), 32'(e.data));
    end
  endtask

  // Holding-register rules and event scoreboard, sampled mid-cycle.
  initial begin
    logic ld;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_outputs", 32'({data_out, data_valid, frame_err, overrun}), 0);
        pv = 1'b0; pr = 1'b0; pd = '0;
      end else begin
        ld = data_valid && (!pv || pr);
        if (pv && !pr) chk("hold_valid", 32'(data_valid), 1);
        if (!ld)       chk("out_stable", 32'(data_out), 32'(pd));
        chk("no_dual_pulse", 32'(frame_err & overrun), 0);
        if (ld)        take(K_DELIV, "deliv");
        if (overrun)   take(K_DROP, "drop");
        if (frame_err) take(K_FERR, "ferr");
        pv = data_valid; pr = data_ready; pd = data_out;
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < DATA_BITS; i++) hold(b[i], BIT);
    hold(stop, BIT);
  endtask

  task automatic drain(input string nm);
    chk({"drain_", nm}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    int  t0, lat;
    bit  found;
    logic [7:0] c3;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b1, BIT);

    // 0xA5 with latency window and single-cycle valid
    push(K_DELIV, 8'hA5);
    t0 = cyc;
    found = 1'b0;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 800 && !found; i++) begin
          @(negedge clk);
          if (data_valid) begin
            found = 1'b1;
            lat = cyc - t0;
          end
        end
        chk("a5_seen", 32'(found), 1);
        chk("a5_latency_ok", 32'(lat >= 608 && lat <= 616), 1);
        chk("a5_data", 32'(data_out), 32'h A5);
        @(negedge clk);
        chk("a5_pulse_1clk", 32'(data_valid), 0);
      end
    join
    hold(1'b1, BIT);
    drain("a5");

    // start-bit glitch rejected, then a clean frame
    hold(1'b0, 16);
    hold(1'b1, 2 * BIT);
    chk("glitch_no_valid", 32'(data_valid), 0);
    push(K_DELIV, 8'h5A);
    send_frame(8'h5A, 1'b1);
    hold(1'b1, BIT);
    drain("glitch_5a");

    // bad stop bit followed by a break, then a good frame
    push(K_FERR, 8'h00);
    push(K_DELIV, 8'h55);
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 3 * BIT);
    hold(1'b1, 2 * BIT);
    send_frame(8'h55, 1'b1);
    hold(1'b1, BIT);
    chk("break_last_data", 32'(data_out), 32'h55);
    drain("break");

    // overrun with stalled consumer
    data_ready = 1'b0;
    push(K_DELIV, 8'h11);
    push(K_DROP, 8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, BIT);
    chk("ovr_valid_held", 32'(data_valid), 1);
    chk("ovr_data_held", 32'(data_out), 32'h11);
    drain("overrun");
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    @(negedge clk);
    chk("accept_clears_valid", 32'(data_valid), 0);
    chk("accept_keeps_data", 32'(data_out), 32'h11);
    data_ready = 1'b1;
    hold(1'b1, BIT);

    // back-to-back frames, one stop bit each
    push(K_DELIV, 8'h00);
    push(K_DELIV, 8'hFF);
    push(K_DELIV, 8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    hold(1'b1, BIT);
    chk("b2b_last_data", 32'(data_out), 32'h81);
    drain("b2b");

    // reset in the middle of data bit 4, with a held byte pending
    data_ready = 1'b0;
    push(K_DELIV, 8'h99);
    send_frame(8'h99, 1'b1);
    hold(1'b1, BIT);
    chk("pre_rst_valid", 32'(data_valid), 1);
    drain("pre_rst");
    c3 = 8'hC3;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(c3[i], BIT);
    hold(c3[4], BIT / 2);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({data_out, data_valid, frame_err, overrun}), 0);
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    reset_n = 1'b1;
    data_ready = 1'b1;
    hold(1'b1, 2 * BIT);
    chk("post_rst_quiet", 32'(data_valid), 0);
    push(K_DELIV, 8'h7E);
    send_frame(8'h7E, 1'b1);
    hold(1'b1, BIT);
    chk("post_rst_data", 32'(data_out), 32'h7E);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Baud-accurate UART receiver for standard 8N1 serial lines from external devices, or from a transmitter running at a real baud rate.
- Samples the asynchronous rx line at 16x the bit rate and validates the start bit at mid-bit.
- Samples each data bit and the stop bit at their centres.
- Delivers bytes through a one-entry valid/ready holding register, with framing-error and overrun reporting.

Parameters:
- CLK_DIV, 27, clk cycles per oversample tick (bit period = 16*CLK_DIV clocks); legal range 2..65535.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous to clk, idle high
- data_out  output  DATA_BITS  received byte, stable while data_valid=1
- data_valid  output  1  holding register full
- data_ready  input  1  consumer accepts data_out when data_valid=1
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped because holding register full

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0:
  - data_out=0, data_valid=0, frame_err=0, overrun=0.
  - Synchroniser flops=1, state=IDLE, all counters=0.
  - Reset asserted mid-frame aborts the frame immediately, with no pulses.
- Synchroniser: two flops on rx produce rx_s; all decisions use rx_s.
- Tick generator: free-running counter 0..CLK_DIV-1; tick=1 for one clk when counter==CLK_DIV-1, then wraps to 0.
- os_cnt (4 bits) advances only on tick. bit_idx counts received data bits.
- FSM states: IDLE, START, DATA, STOP, BREAK_WAIT.
  - IDLE: rx_s==0 -> START, os_cnt=0.
  - START: on the tick where os_cnt==7:
    - rx_s==0 -> DATA, os_cnt=0, bit_idx=0.
    - rx_s==1 -> IDLE (glitch rejected, no pulse).
  - DATA: on the tick where os_cnt==15:
    - Shift rx_s into the MSB of the shift register (shift right), os_cnt=0, bit_idx+1.
    - When the sample taken is bit DATA_BITS-1 -> STOP.
  - STOP: on the tick where os_cnt==15:
    - rx_s==1 -> deliver (below), then IDLE.
    - rx_s==0 -> frame_err=1 for one clk, shift register discarded, then BREAK_WAIT.
  - BREAK_WAIT: remain until rx_s==1, then IDLE. A held-low line (break) yields exactly one frame_err.
- Delivery, in the clk of the stop-bit sample:
  - If data_valid==0, or data_valid&data_ready this cycle: data_out<=shift register, data_valid<=1.
  - Else: overrun=1 for one clk; data_out and data_valid unchanged; new byte lost.
- Consumption: data_valid&data_ready with no load in the same cycle -> data_valid<=0 next clk. data_out holds its last value.
- A simultaneous accept and load keeps data_valid=1 with the new byte; no overrun.
- frame_err and overrun are registered and never both high in the same clk.
- Latency: data_valid rises 9.5 bit periods + 2 sync clks + 0..CLK_DIV clks (tick phase) + 1 clk after the falling start edge.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge at the end of the stop bit is caught.
- Tolerated baud mismatch: about ±3%.

Test Plan:
- Default: CLK_DIV=4 (64 clk/bit), DATA_BITS=8.
- Frame 0xA5 8N1 at 64 clk/bit, data_ready=1 -> data_out=0xA5, data_valid high exactly 1 clk, rising 608..616 clks after the start edge; frame_err=overrun=0.
- rx low pulse of 16 clks, then high -> FSM returns to IDLE; no data_valid, no frame_err. Then frame 0x5A -> received 0x5A.
- Frame 0x3C with stop bit low, line held low 3 bit times, then high, then frame 0x55:
  - Exactly one frame_err pulse.
  - No data_valid for 0x3C.
  - Then data_out=0x55 with data_valid=1.
- data_ready=0; frames 0x11 then 0x22:
  - data_valid=1, data_out=0x11 held.
  - One overrun pulse at the second stop sample.
  - Raise data_ready for 1 clk -> data_valid=0, data_out stays 0x11.
- Back-to-back frames 0x00, 0xFF, 0x81 with one stop bit each, data_ready=1 -> three data_valid pulses carrying 0x00, 0xFF, 0x81 in order, no errors.
- reset_n=0 for 3 clks during DATA bit 4 of frame 0xC3 -> all outputs 0 immediately, FSM in IDLE. Next frame 0x7E -> received correctly, no spurious pulses.
